rr_resource_arbiter: RTL

- Round-robin arbiter that shares one single-port register-bank access channel between NUM_REQ requesters.
- Locks the grant for a burst, so a burst is never interleaved with another requester's beats.
- Caps burst length so no requester can starve the others.
- Sits between the test agents and the shared resource port, inside the same test package/timescale domain (1ns/1ps).

---
 rtl/rr_resource_arbiter_pkg.sv | 38 +++
 rtl/rr_resource_arbiter_pick_comb.sv | 29 ++
 rtl/rr_resource_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rr_resource_arbiter_pkg.sv
// rtl/rr_resource_arbiter_pkg.sv - shared types and round-robin pick function for the resource arbiter
package rr_resource_arbiter_pkg;

  localparam int MAX_NUM_REQ = 16;
  localparam int MAX_IDX_W   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First asserted request at or after pointer, wrapping at num_req.
  // pointer < num_req and k < num_req, so one conditional subtract replaces a modulo.
  function automatic pick_t rr_pick(input logic [MAX_NUM_REQ-1:0] req,
                                    input logic [MAX_IDX_W-1:0]   pointer,
                                    input int                     num_req);
    pick_t                res;
    int                   cand;
    logic [MAX_IDX_W-1:0] ci;
    res = '0;
    for (int k = 0; k < MAX_NUM_REQ; k++) begin
      cand = int'(pointer) + k;
      if (cand >= num_req) cand = cand - num_req;
      ci = cand[MAX_IDX_W-1:0];
      if ((k < num_req) && !res.found && req[ci]) begin
        res.found = 1'b1;
        res.idx   = ci;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_resource_arbiter_pick_comb.sv
// rtl/rr_resource_arbiter_pick_comb.sv - combinational rotate/priority-encode for round-robin selection
module rr_pick_comb
  import rr_resource_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [MAX_NUM_REQ-1:0] req_ext;
  logic [MAX_IDX_W-1:0]   ptr_ext;
  pick_t                  pick;

  // Widen to the package's fixed width and pick the next requester from the pointer
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = '0;
    ptr_ext[IDX_W-1:0]     = pointer;
    pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    idx                    = pick.idx[IDX_W-1:0];
    found                  = pick.found;
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - burst-locking round-robin arbiter; optional stats via RR_RESOURCE_ARBITER_STATS_EN
module rr_resource_arbiter
  import rr_resource_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int ADDR_W   = 8,
  parameter  int DATA_W   = 32,
  parameter  int MAX_HOLD = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_write,
  output logic [ADDR_W-1:0]         res_addr,
  output logic [DATA_W-1:0]         res_wdata,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
`ifdef RR_RESOURCE_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants,
  output logic [15:0]               stat_forced
`endif
);

  localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_e             state;
  logic [IDX_W-1:0]   pointer;
  logic [7:0]         beat_cnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               beat;
  logic               last_hit;
  logic               hold_hit;
  logic               release_now;
  logic [IDX_W-1:0]   next_ptr;

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req_valid),
    .pointer (pointer),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  // Owner's channel is passed straight through while a grant is held
  always_comb begin
    res_valid = 1'b0;
    req_ready = '0;
    res_write = 1'b0;
    res_addr  = '0;
    res_wdata = '0;
    if (state == OWN) begin
      res_valid           = req_valid[grant_id];
      req_ready[grant_id] = res_ready;
      res_write           = req_write[grant_id];
      res_addr            = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      res_wdata           = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
    end
  end

  // Release decision: burst end or hold cap reached on a transferred beat
  always_comb begin
    beat        = res_valid & res_ready;
    last_hit    = req_last[grant_id];
    hold_hit    = (beat_cnt == HOLD_LAST);
    release_now = beat & (last_hit | hold_hit);
    next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
  end

  // Grant FSM: pick in IDLE, hold through the burst in OWN, rotate pointer on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      busy     <= 1'b0;
      pointer  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= OWN;
          end
        end
        OWN: begin
          if (release_now) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pointer  <= next_ptr;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_RESOURCE_ARBITER_STATS_EN
  // Saturating grant and forced-release counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_forced <= '0;
    end else begin
      if ((state == IDLE) && pick_found &&
          (stat_grants[int'(pick_idx)*16 +: 16] != 16'hFFFF)) begin
        stat_grants[int'(pick_idx)*16 +: 16] <= stat_grants[int'(pick_idx)*16 +: 16] + 16'd1;
      end
      if (beat && hold_hit && !last_hit && (stat_forced != 16'hFFFF)) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

  // A stalled beat must keep valid high and its payload stable until accepted
  property p_stall_stable;
    @(posedge clk) disable iff (!rst_n)
      (res_valid && !res_ready) |=>
        (res_valid && $stable(res_addr) && $stable(res_wdata) && $stable(res_write));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

endmodule
